// File: rtl/fmap_buf_pkg.sv
// fmap_buf_pkg: shared types and width helper for the
// ping-pong feature-map buffer.
package fmap_buf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fmap_bank.sv
// fmap_bank: one feature-map bank with per-channel write
// counters, bank state and an asynchronous read port.
module fmap_bank
  import fmap_buf_pkg::*;
#(
  parameter int K  = 4,
  parameter int BW = 32,
  parameter int PE = 2,
  parameter int P  = 4
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  wr_sel,
  input  logic [K-1:0]          wr_mask,
  input  logic [PE-1:0][BW-1:0] wr_data,
  input  logic                  rd_start,
  input  logic                  rd_done,
  input  logic [cnt_w(K*P)-1:0] rd_addr,
  output logic [BW-1:0]         rd_data,
  output bank_state_t           state,
  output logic                  wr_open,
  output logic                  wr_over,
  output logic                  filled
);
  localparam int CW = cnt_w(P + 1);
  localparam int AW = cnt_w(K * P);
  localparam logic [CW-1:0] PMAX  = CW'(P);
  localparam logic [CW-1:0] PLAST = CW'(P - 1);

  logic [BW-1:0] mem [K*P];
  logic [CW-1:0] cnt [K];
  logic [K-1:0]  wr_ch;
  logic [K-1:0]  ch_done;
  bank_state_t   state_q;
  bank_state_t   state_d;

  always_comb begin
    wr_open = (state_q == BANK_EMPTY) ||
              (state_q == BANK_FILLING);
    wr_over = 1'b0;
    wr_ch   = '0;
    ch_done = '0;
    for (int c = 0; c < K; c++) begin
      wr_ch[c] = wr_sel && wr_open && wr_mask[c] &&
                 (cnt[c] != PMAX);
      wr_over  = wr_over || (wr_sel && wr_open &&
                 wr_mask[c] && (cnt[c] == PMAX));
      ch_done[c] = (cnt[c] == PMAX) ||
                   (wr_ch[c] && (cnt[c] == PLAST));
    end
    filled = (&ch_done) && (|wr_ch);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BANK_EMPTY, BANK_FILLING: begin
        if (filled)      state_d = BANK_FULL;
        else if (|wr_ch) state_d = BANK_FILLING;
      end
      BANK_FULL:
        if (rd_start) state_d = BANK_DRAINING;
      BANK_DRAINING:
        if (rd_done) state_d = BANK_EMPTY;
      default: state_d = BANK_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= BANK_EMPTY;
      for (int c = 0; c < K; c++) cnt[c] <= '0;
    end else begin
      state_q <= state_d;
      for (int c = 0; c < K; c++) begin
        if (filled)        cnt[c] <= '0;
        else if (wr_ch[c]) cnt[c] <= cnt[c] + 1'b1;
      end
    end
  end

  // Pixel storage needs no reset; reads are gated by bank state.
  always_ff @(posedge clk) begin
    for (int c = 0; c < K; c++) begin
      if (wr_ch[c])
        mem[AW'(c * P) + AW'(cnt[c])] <= wr_data[c % PE];
    end
  end

  assign rd_data = mem[rd_addr];
  assign state   = state_q;

endmodule

// File: rtl/pingpong_fmap_buffer.sv
// pingpong_fmap_buffer: two-bank channel-major reorder buffer.
// Define FMAP_BUF_ERR_CHECK_EN to enable the sticky error flag.
module pingpong_fmap_buffer
  import fmap_buf_pkg::*;
#(
  parameter int NumberOfK          = 4,
  parameter int BitSize            = 32,
  parameter int ProcessingElements = 2,
  parameter int ImageWidth         = 2
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic [NumberOfK-1:0]  in_valid,
  input  logic [ProcessingElements-1:0][BitSize-1:0] in_data,
  output logic                  in_ready,
  output logic [BitSize-1:0]    out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  image_done,
  output logic                  error
);
  localparam int K  = NumberOfK;
  localparam int PE = ProcessingElements;
  localparam int P  = ImageWidth * ImageWidth;
  localparam int CW = cnt_w(P + 1);
  localparam int HW = cnt_w(K);
  localparam int AW = cnt_w(K * P);

  if (K % PE != 0) begin : g_bad_pe
    $error("NumberOfK must be a multiple of ProcessingElements");
  end

  bank_state_t  st [2];
  logic [BitSize-1:0] rdat [2];
  logic [1:0]   wr_open;
  logic [1:0]   wr_over;
  logic [1:0]   filled;
  logic [1:0]   rd_start;
  logic [1:0]   rd_done;
  logic         wr_ptr;
  logic [HW-1:0] rd_ch;
  logic [CW-1:0] rd_pix;
  logic [AW-1:0] rd_addr;
  logic         draining;
  logic         rd_bank;
  logic         last_px;
  logic         last_ch;
  logic         xfer;
  logic         fin;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank #(
      .K (K),
      .BW(BitSize),
      .PE(PE),
      .P (P)
    ) u_bank (
      .clk     (clk),
      .res_n   (res_n),
      .wr_sel  (wr_ptr == 1'(b)),
      .wr_mask (in_valid),
      .wr_data (in_data),
      .rd_start(rd_start[b]),
      .rd_done (rd_done[b]),
      .rd_addr (rd_addr),
      .rd_data (rdat[b]),
      .state   (st[b]),
      .wr_open (wr_open[b]),
      .wr_over (wr_over[b]),
      .filled  (filled[b])
    );
  end

  always_comb begin
    draining = (st[0] == BANK_DRAINING) ||
               (st[1] == BANK_DRAINING);
    rd_bank  = (st[1] == BANK_DRAINING);
    last_px  = (rd_pix == CW'(P - 1));
    last_ch  = (rd_ch == HW'(K - 1));
    xfer     = draining && out_ready;
    fin      = xfer && last_px && last_ch;
    // A waiting bank takes over on the final transfer: no bubble.
    rd_start[0] = (st[0] == BANK_FULL) && (!draining || fin);
    rd_start[1] = (st[1] == BANK_FULL) && (!draining || fin) &&
                  !rd_start[0];
    rd_done[0]  = fin && !rd_bank;
    rd_done[1]  = fin && rd_bank;
    rd_addr     = AW'(int'(rd_ch) * P) + AW'(rd_pix);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= 1'b0;
      rd_ch  <= '0;
      rd_pix <= '0;
    end else begin
      if (|filled) wr_ptr <= ~wr_ptr;
      if (fin) begin
        rd_ch  <= '0;
        rd_pix <= '0;
      end else if (xfer) begin
        if (last_px) begin
          rd_pix <= '0;
          rd_ch  <= rd_ch + 1'b1;
        end else begin
          rd_pix <= rd_pix + 1'b1;
        end
      end
    end
  end

  assign in_ready   = wr_open[wr_ptr];
  assign out_valid  = draining;
  assign out_data   = draining ? rdat[rd_bank] : '0;
  assign out_last   = draining && last_px;
  assign image_done = draining && last_px && last_ch;

`ifdef FMAP_BUF_ERR_CHECK_EN
  localparam logic [K-1:0] GRP = K'((2 ** PE) - 1);
  logic legal;
  logic err_q;

  always_comb begin
    legal = (in_valid == '0);
    for (int g = 0; g < K / PE; g++) begin
      if (in_valid == (GRP << (g * PE))) legal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) err_q <= 1'b0;
    else if ((|in_valid) &&
             (!legal || !in_ready || (|wr_over)))
      err_q <= 1'b1;
  end

  assign error = err_q;
`else
  logic unused_over;
  assign unused_over = |wr_over;
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_pingpong_fmap_buffer.sv
// tb_pingpong_fmap_buffer: random and directed stimulus checked
// each cycle against a queue-based image model.
module tb_pingpong_fmap_buffer;
  localparam int K  = 4;
  localparam int BW = 32;
  localparam int PE = 2;
  localparam int P  = 4;
  localparam int KP = K * P;
`ifdef FMAP_BUF_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  res_n;
  logic [K-1:0]          in_valid;
  logic [PE-1:0][BW-1:0] in_data;
  logic                  in_ready;
  logic [BW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  image_done;
  logic                  error;

  pingpong_fmap_buffer #(
    .NumberOfK(K),
    .BitSize(BW),
    .ProcessingElements(PE),
    .ImageWidth(2)
  ) dut (
    .clk(clk),
    .res_n(res_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .image_done(image_done),
    .error(error)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit legal_pat(input logic [K-1:0] v);
    logic [K-1:0] m;
    for (int g = 0; g < K / PE; g++) begin
      m = '0;
      for (int i = 0; i < PE; i++) m[g*PE+i] = 1'b1;
      if (v == m) return 1'b1;
    end
    return 1'b0;
  endfunction

  // ---------------- reference model ----------------
  logic [BW-1:0] wimg [K][P];
  int            wcnt [K];
  logic [BW-1:0] fullq [$];
  logic [BW-1:0] drain [$];
  int            nfull = 0;
  int            rd_idx = 0;
  bit            draining = 1'b0;
  bit            err_m = 1'b0;
  int            m_held;
  bit m_ready, m_xfer, m_fin, m_start, m_all, m_hit;

  initial forever begin
    @(posedge clk or negedge res_n);
    if (!res_n) begin
      for (int c = 0; c < K; c++) wcnt[c] = 0;
      fullq.delete();
      drain.delete();
      nfull = 0;
      rd_idx = 0;
      draining = 1'b0;
      err_m = 1'b0;
    end else begin
      m_held  = nfull + (draining ? 1 : 0);
      m_ready = (m_held < 2);
      m_xfer  = draining && out_ready;
      m_fin   = m_xfer && (rd_idx == KP - 1);
      m_start = (nfull > 0) && (!draining || m_fin);
      m_hit = 1'b0;
      for (int c = 0; c < K; c++)
        if (in_valid[c] && wcnt[c] == P) m_hit = 1'b1;
      if (in_valid != '0 &&
          (!legal_pat(in_valid) || !m_ready || m_hit))
        err_m = 1'b1;
      if (m_ready) begin
        for (int c = 0; c < K; c++) begin
          if (in_valid[c] && wcnt[c] < P) begin
            wimg[c][wcnt[c]] = in_data[c % PE];
            wcnt[c]++;
          end
        end
        m_all = 1'b1;
        for (int c = 0; c < K; c++)
          if (wcnt[c] != P) m_all = 1'b0;
        if (m_all) begin
          for (int c = 0; c < K; c++)
            for (int p = 0; p < P; p++)
              fullq.push_back(wimg[c][p]);
          for (int c = 0; c < K; c++) wcnt[c] = 0;
          nfull++;
        end
      end
      if (m_xfer) rd_idx++;
      if (m_fin) begin
        draining = 1'b0;
        rd_idx = 0;
        drain.delete();
      end
      if (m_start) begin
        for (int i = 0; i < KP; i++)
          drain.push_back(fullq.pop_front());
        nfull--;
        draining = 1'b1;
      end
    end
  end

  // ---------------- compare / capture ----------------
  logic [BW-1:0] cap_d [$];
  bit            cap_l [$];
  bit            cap_f [$];
  int            cap_t [$];
  int            cyc = 0;
  bit            prev_stall = 1'b0;
  logic [BW-1:0] prev_data;
  logic [BW-1:0] e_data;
  bit            e_last, e_done;

  initial forever begin
    @(negedge clk);
    e_data = draining ? drain[rd_idx] : '0;
    e_last = draining && (rd_idx % P == P - 1);
    e_done = draining && (rd_idx == KP - 1);
    chk("out_valid", out_valid, draining);
    chk("out_data", out_data, e_data);
    chk("out_last", out_last, e_last);
    chk("image_done", image_done, e_done);
    chk("in_ready", in_ready, (nfull + (draining ? 1 : 0)) < 2);
    chk("error", error, ERR_EN ? err_m : 1'b0);
    if (prev_stall && res_n) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, prev_data);
    end
    prev_stall = out_valid && !out_ready && res_n;
    prev_data  = out_data;
    if (out_valid && out_ready && res_n) begin
      cap_d.push_back(out_data);
      cap_l.push_back(out_last);
      cap_f.push_back(image_done);
      cap_t.push_back(cyc);
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 0;
  int pat_i = 0;
  int ready_drops = 0;

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      2: begin
        out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
        pat_i++;
      end
      default: out_ready = ($urandom_range(0, 9) < 7);
    endcase
  end

  task automatic drive(input logic [K-1:0] v,
                       input logic [BW-1:0] d0,
                       input logic [BW-1:0] d1);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_data[0] = d0;
    in_data[1] = d1;
    if (!in_ready) ready_drops++;
  endtask

  task automatic push_image(input int base);
    for (int i = 0; i < P; i++) begin
      drive(4'b0011, BW'(base + 1), BW'(base + 2));
      drive(4'b1100, BW'(base + 3), BW'(base + 4));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0);
  endtask

  task automatic wait_cap(input int n, input int budget,
                          input string nm);
    int c = 0;
    while (cap_d.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk(nm, cap_d.size(), n);
  endtask

  task automatic chk_img(input int off, input int base,
                         input string nm);
    for (int i = 0; i < KP; i++) begin
      if (off + i < cap_d.size()) begin
        chk({nm, "_data"}, cap_d[off+i], base + i / P + 1);
        chk({nm, "_last"}, cap_l[off+i], (i % P) == P - 1);
        chk({nm, "_done"}, cap_f[off+i], i == KP - 1);
      end
    end
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_l.delete();
    cap_f.delete();
    cap_t.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    res_n = 1'b0;
    in_valid = '0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_image_done", image_done, 1'b0);
    chk("rst_error", error, 1'b0);
    @(posedge clk);
    #1;
    res_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_n = 1'b0;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_in_ready", in_ready, 1'b1);
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_out_data", out_data, '0);
    chk("init_error", error, 1'b0);
    @(posedge clk);
    #1;
    res_n = 1'b1;

    // single image, always-ready consumer
    rdy_mode = 1;
    clear_cap();
    push_image(0);
    idle(1);
    wait_cap(KP, 200, "t1_count");
    chk_img(0, 0, "t1");
    idle(5);

    // two images back to back
    clear_cap();
    ready_drops = 0;
    push_image(0);
    push_image(4);
    chk("t2_in_ready_held", ready_drops, 0);
    idle(1);
    wait_cap(2 * KP, 300, "t2_count");
    chk_img(0, 0, "t2a");
    chk_img(KP, 4, "t2b");
    if (cap_t.size() == 2 * KP)
      chk("t2_contig", cap_t[2*KP-1] - cap_t[0], 2 * KP - 1);
    idle(5);

    // stalling consumer 1,0,0,1
    clear_cap();
    pat_i = 0;
    rdy_mode = 2;
    push_image(0);
    idle(1);
    wait_cap(KP, 400, "t3_count");
    chk_img(0, 0, "t3");
    rdy_mode = 1;
    idle(5);

    // overflow: third image dropped
    clear_cap();
    rdy_mode = 0;
    push_image(0);
    push_image(4);
    push_image(8);
    idle(1);
    @(negedge clk);
    chk("t4_in_ready_low", in_ready, 1'b0);
    chk("t4_error", error, ERR_EN);
    rdy_mode = 1;
    wait_cap(2 * KP, 400, "t4_count");
    idle(40);
    chk("t4_no_third", cap_d.size(), 2 * KP);
    chk_img(0, 0, "t4a");
    chk_img(KP, 4, "t4b");

    // reset mid-drain, then a fresh image
    pulse_reset();
    clear_cap();
    rdy_mode = 1;
    push_image(0);
    idle(1);
    wait_cap(5, 100, "t5_pre");
    pulse_reset();
    clear_cap();
    push_image(8);
    idle(1);
    wait_cap(KP, 200, "t5_count");
    idle(30);
    chk("t5_no_partial", cap_d.size(), KP);
    chk_img(0, 8, "t5");

    // randomized traffic against the model
    rdy_mode = 3;
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [K-1:0] v;
      r = $urandom_range(0, 9);
      if (r < 3) v = '0;
      else if (r < 9) v = (r % 2 == 0) ? 4'b0011 : 4'b1100;
      else v = K'($urandom);
      drive(v, $urandom, $urandom);
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end
    rdy_mode = 1;
    idle(80);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
